// File: rtl/resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : resp_pkg
//  Description : Shared defaults and helpers for the response router:
//                default channel count / payload width / FIFO depth, a
//                constant ceil-log2 function and a CPU-ID field extractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package resp_pkg;

    localparam int c_N_CPU_DEF   = 4;
    localparam int c_DATA_W_DEF  = 65;
    localparam int c_DEPTH_DEF   = 8;

    // Widest completed entry (ID + payload) the ID extractor can handle.
    localparam int c_MAX_ENTRY_W = 1024;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Return the ID field sitting above the payload. The caller zero-extends
    // the entry, so everything above the payload is exactly the ID.
    function automatic int unsigned entry_id(input logic [c_MAX_ENTRY_W-1:0] entry,
                                             input int                       data_w);
        logic [c_MAX_ENTRY_W-1:0] s;
        s = entry >> data_w;
        return s[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/response_router_if.sv
`default_nettype none
// ============================================================================
//  Module      : response_router_if
//  Description : Completion-in / per-CPU response-out bundle of the router.
//                master = controller + CPU side, slave = router.
//  Revision    : 1.0 - initial release
// ============================================================================
interface response_router_if
    import resp_pkg::*;
#(
    parameter int N_CPU  = c_N_CPU_DEF,
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int DEPTH  = c_DEPTH_DEF
);

    localparam int c_ID_W  = clog2(N_CPU);
    localparam int c_CNT_W = clog2(DEPTH + 1);

    logic [c_ID_W+DATA_W-1:0] completed_entry;
    logic                     completed_ctrl;
    logic                     completed_ready;
    logic [N_CPU-1:0]         read_res;
    logic [N_CPU*DATA_W-1:0]  res_data;
    logic [N_CPU-1:0]         res_ctrl;
    logic [N_CPU*c_CNT_W-1:0] res_count;
    logic [N_CPU-1:0]         underflow;
    logic                     illegal_id;

    modport master (
        output completed_entry, completed_ctrl, read_res,
        input  completed_ready, res_data, res_ctrl, res_count, underflow, illegal_id
    );

    modport slave (
        input  completed_entry, completed_ctrl, read_res,
        output completed_ready, res_data, res_ctrl, res_count, underflow, illegal_id
    );

endinterface
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : resp_fifo
//  Description : Single-channel first-word-fall-through FIFO. Head data is
//                forced to zero while empty; writes while full and reads
//                while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_fifo
    import resp_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int DEPTH  = c_DEPTH_DEF
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         i_wen,
    input  wire logic [DATA_W-1:0]            i_wdata,
    input  wire logic                         i_ren,
    output logic      [DATA_W-1:0]            o_rdata,
    output logic      [clog2(DEPTH+1)-1:0]    o_count,
    output logic                              o_empty,
    output logic                              o_full
);

    localparam int c_PTR_W = clog2(DEPTH);
    localparam int c_CNT_W = clog2(DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_wr;
    logic               w_do_rd;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_CNT_MAX);
    assign w_do_wr = i_wen & ~o_full;
    assign w_do_rd = i_ren & ~o_empty;
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written at the tail slot, no reset needed since the
    // head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks the
    // net effect of a write and a pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/response_router.sv
`default_nettype none
// ============================================================================
//  Module      : response_router
//  Description : Steers completed memory requests into per-CPU FWFT response
//                FIFOs by the ID field, with backpressure, occupancy counts
//                and sticky underflow / illegal-ID flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module response_router
    import resp_pkg::*;
#(
    parameter int N_CPU  = c_N_CPU_DEF,
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int DEPTH  = c_DEPTH_DEF
) (
    input  wire logic          clk,
    input  wire logic          reset,
    response_router_if.slave   bus
);

    localparam int c_ID_W    = clog2(N_CPU);
    localparam int c_CNT_W   = clog2(DEPTH + 1);
    localparam int c_ENTRY_W = c_ID_W + DATA_W;

    logic [c_MAX_ENTRY_W-1:0] w_entry_ext;
    logic [31:0]              w_tgt;
    logic [DATA_W-1:0]        w_payload;
    logic                     w_legal;
    logic                     w_tgt_full;
    logic                     w_accept;
    logic [N_CPU-1:0]         w_wen;
    logic [N_CPU-1:0]         w_empty;
    logic [N_CPU-1:0]         w_full;
    logic [DATA_W-1:0]        w_rdata [N_CPU];
    logic [c_CNT_W-1:0]       w_count [N_CPU];
    logic [N_CPU-1:0]         r_underflow;
    logic                     r_illegal;

    assign w_entry_ext = {{(c_MAX_ENTRY_W-c_ENTRY_W){1'b0}}, bus.completed_entry};
    assign w_tgt       = entry_id(w_entry_ext, DATA_W);
    assign w_payload   = bus.completed_entry[DATA_W-1:0];
    assign w_legal     = (w_tgt < 32'(N_CPU));

    // Illegal IDs are always accepted (and dropped); legal ones stall only
    // while their own channel is full.
    assign bus.completed_ready = ~w_legal | ~w_tgt_full;
    assign w_accept            = bus.completed_ctrl & bus.completed_ready;

    // Ready mux: full flag of the addressed channel.
    always_comb begin
        w_tgt_full = 1'b0;
        for (int i = 0; i < N_CPU; i++) begin
            if (w_tgt == 32'(i)) begin
                w_tgt_full = w_full[i];
            end
        end
    end

    // Write decode: at most one channel is written per cycle.
    always_comb begin
        w_wen = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (w_tgt == 32'(i)) begin
                w_wen[i] = w_accept & w_legal;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CPU; gi++) begin : g_ch
            resp_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (reset),
                .i_wen   (w_wen[gi]),
                .i_wdata (w_payload),
                .i_ren   (bus.read_res[gi]),
                .o_rdata (w_rdata[gi]),
                .o_count (w_count[gi]),
                .o_empty (w_empty[gi]),
                .o_full  (w_full[gi])
            );

            assign bus.res_data[gi*DATA_W +: DATA_W]    = w_rdata[gi];
            assign bus.res_count[gi*c_CNT_W +: c_CNT_W] = w_count[gi];
        end
    endgenerate

    assign bus.res_ctrl   = ~w_empty;
    assign bus.underflow  = r_underflow;
    assign bus.illegal_id = r_illegal;

    // Sticky error flags: set on a pop of an empty channel or an illegal ID,
    // cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underflow <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_underflow <= r_underflow | (bus.read_res & w_empty);
            if (bus.completed_ctrl && !w_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_response_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_response_router
//  Description : Directed bench for response_router with a queue-based
//                reference model checked every cycle, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_response_router;

    localparam int N     = 4;
    localparam int DW    = 65;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    response_router_if #(.N_CPU(N), .DATA_W(DW), .DEPTH(DEPTH)) bus  ();
    response_router_if #(.N_CPU(3), .DATA_W(DW), .DEPTH(DEPTH)) bus3 ();

    response_router #(.N_CPU(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    response_router #(.N_CPU(3), .DATA_W(DW), .DEPTH(DEPTH)) dut3 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus3)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: one queue per CPU plus the sticky flags.
    logic [DW-1:0] m_q [N][$];
    logic [N-1:0]  m_uf  = '0;
    logic          m_ill = 1'b0;
    int            m_tgt;
    bit            m_acc;

    function automatic void chk(input string nm, input logic [259:0] act, input logic [259:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Model update: decide acceptance from the pre-edge occupancy, then pops,
    // then the push.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_q[i].delete();
            m_uf  = '0;
            m_ill = 1'b0;
        end else begin
            m_tgt = int'(bus.completed_entry[DW+1:DW]);
            m_acc = bus.completed_ctrl && (m_tgt >= N || m_q[m_tgt].size() < DEPTH);
            for (int i = 0; i < N; i++) begin
                if (bus.read_res[i]) begin
                    if (m_q[i].size() > 0) void'(m_q[i].pop_front());
                    else m_uf[i] = 1'b1;
                end
            end
            if (m_acc) begin
                if (m_tgt >= N) m_ill = 1'b1;
                else m_q[m_tgt].push_back(bus.completed_entry[DW-1:0]);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [DW-1:0] e_data;
        int            t;
        t = int'(bus.completed_entry[DW+1:DW]);
        chk("completed_ready", 260'(bus.completed_ready), 260'(m_q[t].size() < DEPTH));
        chk("illegal_id", 260'(bus.illegal_id), 260'(m_ill));
        for (int i = 0; i < N; i++) begin
            e_data = (m_q[i].size() > 0) ? m_q[i][0] : '0;
            chk($sformatf("res_data[%0d]", i), 260'(bus.res_data[i*DW +: DW]), 260'(e_data));
            chk($sformatf("res_ctrl[%0d]", i), 260'(bus.res_ctrl[i]), 260'(m_q[i].size() > 0));
            chk($sformatf("res_count[%0d]", i), 260'(bus.res_count[i*CW +: CW]), 260'(m_q[i].size()));
            chk($sformatf("underflow[%0d]", i), 260'(bus.underflow[i]), 260'(m_uf[i]));
        end
    end

    // One cycle of stimulus; returns just after the following falling edge.
    task automatic drive(input int id, input logic [DW-1:0] d, input logic v, input logic [N-1:0] rd);
        logic [1:0] idb;
        idb = id[1:0];
        bus.completed_entry = {idb, d};
        bus.completed_ctrl  = v;
        bus.read_res        = rd;
        @(negedge clk);
        #1;
        bus.completed_ctrl = 1'b0;
        bus.read_res       = '0;
    endtask

    task automatic pop_chk(input int ch, input logic [DW-1:0] exp);
        logic [N-1:0] rd;
        rd = '0;
        rd[ch] = 1'b1;
        chk($sformatf("head ch%0d", ch), 260'(bus.res_data[ch*DW +: DW]), 260'(exp));
        drive(0, '0, 1'b0, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.completed_entry  = '0;
        bus.completed_ctrl   = 1'b0;
        bus.read_res         = '0;
        bus3.completed_entry = '0;
        bus3.completed_ctrl  = 1'b0;
        bus3.read_res        = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst res_ctrl", 260'(bus.res_ctrl), 260'(0));
        chk("rst res_data", 260'(bus.res_data), 260'(0));
        chk("rst res_count", 260'(bus.res_count), 260'(0));
        chk("rst ready", 260'(bus.completed_ready), 260'(1));

        // Single write to ID 2
        drive(2, 65'h1_DEAD_BEEF, 1'b1, '0);
        chk("w2 res_ctrl", 260'(bus.res_ctrl), 260'(4'b0100));
        chk("w2 data", 260'(bus.res_data[2*DW +: DW]), 260'(65'h1_DEAD_BEEF));
        chk("w2 count", 260'(bus.res_count[2*CW +: CW]), 260'(1));
        pop_chk(2, 65'h1_DEAD_BEEF);

        // Fill ID 1, backpressure, pop-while-full, then drain in order
        for (int k = 0; k < 8; k++) drive(1, 65'(10 + k), 1'b1, '0);
        chk("fill1 count", 260'(bus.res_count[1*CW +: CW]), 260'(8));
        bus.completed_entry = {2'd1, 65'd100};
        #1 chk("full1 ready", 260'(bus.completed_ready), 260'(0));
        bus.completed_entry = {2'd0, 65'd100};
        #1 chk("id0 ready", 260'(bus.completed_ready), 260'(1));
        drive(1, 65'd100, 1'b1, '0);
        chk("9th rejected", 260'(bus.res_count[1*CW +: CW]), 260'(8));
        drive(1, 65'd100, 1'b1, 4'b0010);
        chk("pop at full count", 260'(bus.res_count[1*CW +: CW]), 260'(7));
        drive(1, 65'd100, 1'b1, '0);
        chk("9th accepted", 260'(bus.res_count[1*CW +: CW]), 260'(8));
        for (int k = 1; k < 8; k++) pop_chk(1, 65'(10 + k));
        pop_chk(1, 65'd100);

        // Interleaved IDs 0,3,0,3 then pop both channels together
        drive(0, 65'd1, 1'b1, '0);
        drive(3, 65'd2, 1'b1, '0);
        drive(0, 65'd3, 1'b1, '0);
        drive(3, 65'd4, 1'b1, '0);
        chk("il ch0 head", 260'(bus.res_data[0 +: DW]), 260'(65'd1));
        chk("il ch3 head", 260'(bus.res_data[3*DW +: DW]), 260'(65'd2));
        drive(0, '0, 1'b0, 4'b1001);
        chk("il ch0 second", 260'(bus.res_data[0 +: DW]), 260'(65'd3));
        chk("il ch3 second", 260'(bus.res_data[3*DW +: DW]), 260'(65'd4));
        drive(0, '0, 1'b0, 4'b1001);
        chk("il counts zero", 260'(bus.res_count), 260'(0));

        // Full channel 0 with simultaneous pop and valid write
        for (int k = 0; k < 8; k++) drive(0, 65'(20 + k), 1'b1, '0);
        drive(0, 65'd99, 1'b1, 4'b0001);
        chk("full0 pop count", 260'(bus.res_count[0 +: CW]), 260'(7));
        for (int k = 1; k < 8; k++) pop_chk(0, 65'(20 + k));
        chk("full0 drained", 260'(bus.res_ctrl[0]), 260'(0));

        // Underflow on channel 3, then empty + write + read in one cycle
        drive(0, '0, 1'b0, 4'b1000);
        chk("uf3 set", 260'(bus.underflow), 260'(4'b1000));
        drive(3, 65'd55, 1'b1, 4'b1000);
        chk("uf3 write lands", 260'(bus.res_count[3*CW +: CW]), 260'(1));
        drive(0, '0, 1'b0, '0);
        chk("uf3 sticky", 260'(bus.underflow), 260'(4'b1000));
        pop_chk(3, 65'd55);

        // Sustained traffic: one accept per cycle plus a rotating pop pattern
        for (int k = 0; k < 48; k++) drive(k % 4, 65'(k * 7 + 3), 1'b1, 4'(k * 5));

        // Smaller build: illegal ID is consumed and dropped
        bus3.completed_entry = {2'd3, 65'h5};
        bus3.completed_ctrl  = 1'b1;
        #1 chk("n3 illegal ready", 260'(bus3.completed_ready), 260'(1));
        @(negedge clk);
        #1 bus3.completed_ctrl = 1'b0;
        chk("n3 illegal_id", 260'(bus3.illegal_id), 260'(1));
        chk("n3 counts", 260'(bus3.res_count), 260'(0));
        chk("n3 res_ctrl", 260'(bus3.res_ctrl), 260'(0));
        bus3.completed_entry = {2'd2, 65'h7};
        bus3.completed_ctrl  = 1'b1;
        @(negedge clk);
        #1 bus3.completed_ctrl = 1'b0;
        chk("n3 ch2 count", 260'(bus3.res_count), 260'(12'h100));
        chk("n3 ch2 data", 260'(bus3.res_data[2*DW +: DW]), 260'(65'h7));
        chk("n3 illegal sticky", 260'(bus3.illegal_id), 260'(1));

        // Asynchronous reset mid-stream, checked before the next rising edge
        drive(1, 65'h77, 1'b1, '0);
        drive(2, 65'h78, 1'b1, '0);
        #2 rst = 1'b1;
        #1;
        chk("arst res_ctrl", 260'(bus.res_ctrl), 260'(0));
        chk("arst res_data", 260'(bus.res_data), 260'(0));
        chk("arst res_count", 260'(bus.res_count), 260'(0));
        chk("arst underflow", 260'(bus.underflow), 260'(0));
        chk("arst n3 illegal", 260'(bus3.illegal_id), 260'(0));
        chk("arst n3 count", 260'(bus3.res_count), 260'(0));
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        drive(1, 65'h42, 1'b1, '0);
        chk("post-rst write", 260'(bus.res_data[1*DW +: DW]), 260'(65'h42));
        drive(0, '0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/response_router.md
# response_router

Parametrised successor of the per-CPU response FIFO stage. It accepts completed memory requests from the controller's completion path and steers each one into the response FIFO of the CPU named in its ID field. Each CPU drains its own FIFO independently. Unlike the previous fixed 4-CPU stage, it adds:
- configurable CPU count, payload width and FIFO depth;
- backpressure toward the controller;
- per-channel occupancy counts;
- sticky underflow and illegal-ID error flags.

## Interface
Parameters:
- N_CPU, 4, number of CPU response channels (≥2)
- DATA_W, 65, payload width per response (data + read/write flag)
- DEPTH, 8, entries per channel FIFO; must be a power of two, ≥2
- ID_W (derived), clog2(N_CPU), width of the CPU ID field
- CNT_W (derived), clog2(DEPTH+1), width of each occupancy count

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- completed_entry  in  ID_W+DATA_W  completed request: [ID_W+DATA_W-1 -: ID_W] = CPU ID, [DATA_W-1:0] = payload
- completed_ctrl  in  1  completed_entry valid
- completed_ready  out  1  router can accept completed_entry this cycle
- read_res  in  N_CPU  per-channel pop request
- res_data  out  N_CPU*DATA_W  head payload; channel i at [i*DATA_W +: DATA_W]
- res_ctrl  out  N_CPU  channel i head valid (FIFO non-empty)
- res_count  out  N_CPU*CNT_W  channel i occupancy at [i*CNT_W +: CNT_W], range 0..DEPTH
- underflow  out  N_CPU  sticky; read_res[i] seen while res_ctrl[i]=0
- illegal_id  out  1  sticky; valid entry seen with ID ≥ N_CPU

## Operation
- Decode: tgt = completed_entry ID field.
  - If tgt < N_CPU, the target is channel tgt.
  - Otherwise the ID is illegal.
- Ready rule: completed_ready = (ID illegal) | ~full[tgt]. This is combinational from completed_entry. full[i] = (count[i] == DEPTH).
- Accept: completed_ctrl & completed_ready.
  - Legal ID: the payload is written to channel tgt at the head of the next clock edge order (tail slot).
  - Illegal ID: the entry is consumed and dropped, and illegal_id is set.
  - Only one channel is written per cycle.
- Per-channel FIFO:
  - First-word-fall-through. res_ctrl[i] = (count[i] != 0).
  - res_data slice i = memory[rd_ptr[i]] when non-empty, else all zeros.
- Pop: read_res[i] & res_ctrl[i] advances rd_ptr[i].
  - read_res[i] while empty has no effect on the pointers and sets underflow[i].
- Pointers are ID_W-independent, log2(DEPTH) bits wide, and wrap naturally modulo DEPTH.
- count[i] update per cycle:
  - +1 on write only;
  - −1 on pop only;
  - unchanged on simultaneous write and pop, or on neither.
- Full + pop same cycle: the write is not accepted, because ready was already low from the full flag. There is no bypass.
- Empty + write + read same cycle: the read is ignored and underflow is set. The write lands, and the entry is visible the next cycle.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous assert): all counts and pointers are 0.
  - res_ctrl = 0, res_data = 0, res_count = 0, underflow = 0, illegal_id = 0.
  - completed_ready = 1 for every ID.
- Write latency is 1 cycle: an entry accepted at edge k appears at the channel head (res_ctrl high) after edge k if the channel was empty.
- Pop takes effect at the edge where read_res[i] & res_ctrl[i]; the next entry (or empty) is presented after that edge.
- Full sustained throughput: one accept per cycle into the router plus one pop per cycle per channel.
- Reset mid-operation: all queued entries are discarded immediately. Outputs go to reset values without waiting for clk.

## Structure
- Shared package `resp_pkg`: N_CPU / DATA_W / DEPTH defaults, an ID-field extraction helper, and a clog2 constant function.
- Sub-module `resp_fifo`: a single-channel FWFT FIFO with (DATA_W, DEPTH) parameters, wen/ren/count/empty/full ports, and asynchronous reset. It is instantiated N_CPU times in a generate loop.
- The top level holds the ID decode, the ready mux, the illegal_id flag, the per-channel underflow flags, and the output flattening.

## Test plan
- Reset, then write ID=2 payload 65'h1_DEAD_BEEF → after the next edge, res_ctrl = 4'b0100, channel 2 data = 65'h1_DEAD_BEEF, res_count[2] = 1.
- Push 8 entries to ID=1 (DEPTH=8), with no reads → count 8, completed_ready = 0 for ID=1 while still 1 for ID=0. A 9th push with valid high is not accepted; pop once → ready returns, 9th entry accepted, FIFO order preserved.
- Interleave IDs 0,3,0,3 with values 1,2,3,4, then pop both channels → channel 0 yields 1,3 and channel 3 yields 2,4; all counts return to 0.
- Full channel 0 with simultaneous pop and valid write → one entry leaves, the write is not accepted, and the count becomes 7.
- read_res[3] while empty → underflow[3] = 1 and stays 1. Pointers are unchanged: the next write/read returns the written value.
- Build with N_CPU=3 and send ID=3 → completed_ready = 1, entry dropped, illegal_id = 1, no channel count changes. Assert reset mid-stream → all outputs return to zero asynchronously.
